game_state_ctl: RTL and testbench
=================================

# game_state_ctl

Sequencer that owns `game_state` for the screen-select datapath. It decides when the design moves between the START menu, LEVEL_1 gameplay and the FINISH screen, based on mouse clicks, player position and door-button state. All state changes are committed only on frame boundaries, so the VGA output mux never switches mid-frame. It sits between the mouse/player controllers and the game-screen compositor, driving that compositor's `game_state` input.

## Interface
Parameters:
- `START_BTN_X`, default 350: left edge of the clickable start button, in pixels.
- `START_BTN_Y`, default 280: top edge of the start button.
- `START_BTN_W`, default 100: width of the start button.
- `START_BTN_H`, default 40: height of the start button.
- `EXIT_X`, default 740: left edge of the level-exit region.
- `EXIT_Y`, default 500: top edge of the exit region.
- `EXIT_W`, default 60: width of the exit region.
- `EXIT_H`, default 100: height of the exit region.
- `FINISH_FRAMES`, default 180: number of frames FINISH is shown; must be ≥1.

Ports:
- `clk_40`  in  1: system pixel clock, 40 MHz.
- `rst`  in  1: synchronous, active-high reset.
- `mouse_left`  in  1: raw left-button level from the mouse controller; asynchronous to `clk_40`.
- `xpos_mouse`, `ypos_mouse`  in  12 each: cursor position.
- `xpos_player`, `ypos_player`  in  12 each: player top-left position.
- `button_pressed`  in  1: door button is currently held.
- `vblnk`  in  1: vertical blank from the VGA timing chain, synchronous to `clk_40`.
- `game_state`  out  `g_state`: registered current screen, one of START, LEVEL_1 or FINISH.
- `level_start`  out  1: one-cycle pulse when the state enters LEVEL_1. It is used to reset the player and rectangle controllers.
- `frame_tick`  out  1: one-cycle pulse per frame.

## Operation
- `frame_tick` marks the rising edge of `vblnk`.
- The click event is the rising edge of `mouse_left`, taken after a 2-flop synchronizer.
- Hit tests:
  - Inclusive low bound, exclusive high bound: hit when `x >= X` and `x < X+W`; the same rule applies to y.
  - Sums are computed at 13 bits, so there is no wrap.
  - Start hit uses the mouse position. Exit hit uses the player position.
- START:
  - A click edge with a start hit sets `start_pend`.
  - On `frame_tick` with `start_pend`=1, the next state is LEVEL_1 and `start_pend` clears.
  - A click outside the button is ignored. A held button does not retrigger.
- LEVEL_1:
  - On `frame_tick`, if exit hit and `button_pressed` are both 1, the next state is FINISH and `fin_cnt` is cleared.
  - Clicks are ignored and `start_pend` is held at 0.
- FINISH:
  - Each `frame_tick` increments `fin_cnt`.
  - On the tick where `fin_cnt == FINISH_FRAMES-1`, the next state is START.
  - Clicks are ignored.
- An illegal state encoding recovers to START on the next clock.
- `level_start` asserts for exactly the first cycle in which `game_state` == LEVEL_1.

## Timing
- Reset values: `game_state`=START, `level_start`=0, `frame_tick`=0, `start_pend`=0, `fin_cnt`=0, all sync and edge flops 0.
- Reset mid-level or mid-finish returns to START on the next clock after `rst` is sampled high.
- `frame_tick` is registered. If `vblnk` rises at cycle N (sampled 0 at N-1, 1 at N), `frame_tick` is 1 at N+1.
- `game_state` changes at the clock after `frame_tick` is high, i.e. N+2. `level_start` is high at N+2 only.
- Click path latency: a `mouse_left` rise sampled at cycle M gives a click edge visible at M+3.
- Simultaneous click edge and `frame_tick` in START: the click counts for that tick, so the state changes on the next clock.
- Exit condition true only between ticks: no transition. Only the value at the tick matters.
- `fin_cnt` width: `$clog2(FINISH_FRAMES+1)`.
- With `FINISH_FRAMES`=1, FINISH lasts exactly one frame.
- `game_state` changes at most once per frame.

## Structure
- `g_state` (START, LEVEL_1, FINISH) stays in `state_pkg`.
- Default button and exit geometry constants live in `state_pkg` and are used as parameter defaults.
- Sub-module `sync_edge`: optional 2-flop synchronizer plus rising-edge register, selected by parameter `SYNC`.
  - One instance on `mouse_left` with `SYNC`=1.
  - One instance on `vblnk` with `SYNC`=0.
- The FSM, hit comparators and `fin_cnt` are implemented in `game_state_ctl` itself.

## Test plan
- Reset, then 3 frames with no input -> `game_state` stays START, one `frame_tick` per `vblnk` rise, `level_start` never asserted.
- Mouse at (400,300), click in mid-frame -> START until 2 cycles after the next `vblnk` rise, then LEVEL_1 with a single-cycle `level_start`. A second click while held has no effect.
- Mouse at (450,300), i.e. x = X+W, click -> no transition over 2 frames.
- LEVEL_1, player at (760,550) with `button_pressed`=1 across a tick -> FINISH. Same position with `button_pressed` dropping before the tick -> stays LEVEL_1.
- FINISH with `FINISH_FRAMES`=4 -> returns to START exactly 2 cycles after the 4th tick. Clicks during FINISH are ignored.
- Assert `rst` one cycle in LEVEL_1 and again mid-FINISH -> START on the next clock and `fin_cnt`=0. A click edge coincident with a tick in START transitions immediately.

Source files
------------

// File: rtl/state_pkg.sv
// Shared types and default geometry for the screen-select sequencer.
package state_pkg;

   // Screen currently shown by the compositor.
   typedef enum logic [1:0] {
      START   = 2'b00,
      LEVEL_1 = 2'b01,
      FINISH  = 2'b10
   } g_state;

   // Default start-button rectangle, in pixels.
   localparam int unsigned DEF_START_BTN_X = 350;
   localparam int unsigned DEF_START_BTN_Y = 280;
   localparam int unsigned DEF_START_BTN_W = 100;
   localparam int unsigned DEF_START_BTN_H = 40;

   // Default level-exit rectangle, in pixels.
   localparam int unsigned DEF_EXIT_X = 740;
   localparam int unsigned DEF_EXIT_Y = 500;
   localparam int unsigned DEF_EXIT_W = 60;
   localparam int unsigned DEF_EXIT_H = 100;

   // Half-open range test done at 13 bits so lo+width can never wrap.
   function automatic logic in_range(input logic [11:0] v, input logic [12:0] lo,
                                     input logic [12:0] hi);
      return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Optional 2-flop synchronizer followed by a registered rising-edge detector.
// The edge pulse lags the (synchronized) input by two registers, so a rise
// sampled at cycle N produces a one-cycle pulse at N+1 (SYNC=0) or N+3 (SYNC=1).
module sync_edge #(
   parameter bit SYNC = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o
);

   logic d_in;
   logic d_q;
   logic d_prev_q;
   logic rise_q;

   generate
      if (SYNC) begin : g_sync
         logic s1_q;
         logic s2_q;

         // Two-flop synchronizer for an input asynchronous to clk_i.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               s1_q <= 1'b0;
               s2_q <= 1'b0;
            end else begin
               s1_q <= d_i;
               s2_q <= s1_q;
            end
         end

         assign d_in = s2_q;
      end else begin : g_nosync
         assign d_in = d_i;
      end
   endgenerate

   // Capture the level, keep its previous value and register the rise pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d_q      <= 1'b0;
         d_prev_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         d_q      <= d_in;
         d_prev_q <= d_q;
         rise_q   <= d_q & ~d_prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/game_state_ctl.sv
// Screen-select sequencer: START -> LEVEL_1 -> FINISH -> START.
// Every state change is committed on the clock after frame_tick, so the
// downstream VGA mux only ever switches inside vertical blank.
module game_state_ctl
   import state_pkg::*;
#(
   parameter int unsigned START_BTN_X   = DEF_START_BTN_X,
   parameter int unsigned START_BTN_Y   = DEF_START_BTN_Y,
   parameter int unsigned START_BTN_W   = DEF_START_BTN_W,
   parameter int unsigned START_BTN_H   = DEF_START_BTN_H,
   parameter int unsigned EXIT_X        = DEF_EXIT_X,
   parameter int unsigned EXIT_Y        = DEF_EXIT_Y,
   parameter int unsigned EXIT_W        = DEF_EXIT_W,
   parameter int unsigned EXIT_H        = DEF_EXIT_H,
   parameter int unsigned FINISH_FRAMES = 180
) (
   input  logic        clk_40,
   input  logic        rst,
   input  logic        mouse_left,
   input  logic [11:0] xpos_mouse,
   input  logic [11:0] ypos_mouse,
   input  logic [11:0] xpos_player,
   input  logic [11:0] ypos_player,
   input  logic        button_pressed,
   input  logic        vblnk,
   output g_state      game_state,
   output logic        level_start,
   output logic        frame_tick
);

   // Rectangle bounds, low inclusive / high exclusive, widened to 13 bits.
   localparam logic [12:0] BTN_X_LO  = 13'(START_BTN_X);
   localparam logic [12:0] BTN_X_HI  = 13'(START_BTN_X + START_BTN_W);
   localparam logic [12:0] BTN_Y_LO  = 13'(START_BTN_Y);
   localparam logic [12:0] BTN_Y_HI  = 13'(START_BTN_Y + START_BTN_H);
   localparam logic [12:0] EXIT_X_LO = 13'(EXIT_X);
   localparam logic [12:0] EXIT_X_HI = 13'(EXIT_X + EXIT_W);
   localparam logic [12:0] EXIT_Y_LO = 13'(EXIT_Y);
   localparam logic [12:0] EXIT_Y_HI = 13'(EXIT_Y + EXIT_H);

   localparam int unsigned CntW = $clog2(FINISH_FRAMES + 1);
   localparam logic [CntW-1:0] FinLast = CntW'(FINISH_FRAMES - 1);

   g_state          state_q, state_d;
   logic            start_pend_q, start_pend_d;
   logic [CntW-1:0] fin_cnt_q, fin_cnt_d;
   logic            level_start_q, level_start_d;

   logic click_rise;
   logic tick;
   logic start_hit;
   logic exit_hit;

   // Mouse button is asynchronous: synchronize before edge detection.
   sync_edge #(
      .SYNC (1'b1)
   ) u_click_edge (
      .clk_i  (clk_40),
      .rst_i  (rst),
      .d_i    (mouse_left),
      .rise_o (click_rise)
   );

   // vblnk already lives in the clk_40 domain.
   sync_edge #(
      .SYNC (1'b0)
   ) u_frame_edge (
      .clk_i  (clk_40),
      .rst_i  (rst),
      .d_i    (vblnk),
      .rise_o (tick)
   );

   // Hit comparators: start button follows the cursor, exit follows the player.
   always_comb begin
      start_hit = in_range(xpos_mouse, BTN_X_LO, BTN_X_HI) &&
                  in_range(ypos_mouse, BTN_Y_LO, BTN_Y_HI);
      exit_hit  = in_range(xpos_player, EXIT_X_LO, EXIT_X_HI) &&
                  in_range(ypos_player, EXIT_Y_LO, EXIT_Y_HI);
   end

   // Next-state logic; transitions only ever fire on a frame tick.
   always_comb begin
      state_d      = state_q;
      start_pend_d = start_pend_q;
      fin_cnt_d    = fin_cnt_q;
      case (state_q)
         START: begin
            // A click landing on the same cycle as the tick still counts.
            start_pend_d = start_pend_q | (click_rise & start_hit);
            if (tick && start_pend_d) begin
               state_d      = LEVEL_1;
               start_pend_d = 1'b0;
            end
         end
         LEVEL_1: begin
            start_pend_d = 1'b0;
            if (tick && exit_hit && button_pressed) begin
               state_d   = FINISH;
               fin_cnt_d = '0;
            end
         end
         FINISH: begin
            start_pend_d = 1'b0;
            if (tick) begin
               if (fin_cnt_q == FinLast) begin
                  state_d   = START;
                  fin_cnt_d = '0;
               end else begin
                  fin_cnt_d = fin_cnt_q + CntW'(1);
               end
            end
         end
         default: begin
            // Illegal encoding: fall back to the menu with clean side state.
            state_d      = START;
            start_pend_d = 1'b0;
            fin_cnt_d    = '0;
         end
      endcase
      level_start_d = (state_d == LEVEL_1) && (state_q != LEVEL_1);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_40) begin
      if (rst) begin
         state_q       <= START;
         start_pend_q  <= 1'b0;
         fin_cnt_q     <= '0;
         level_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_pend_q  <= start_pend_d;
         fin_cnt_q     <= fin_cnt_d;
         level_start_q <= level_start_d;
      end
   end

   assign game_state  = state_q;
   assign level_start = level_start_q;
   assign frame_tick  = tick;

endmodule

// File: tb/tb_game_state_ctl.sv
// Directed bench for game_state_ctl with FINISH_FRAMES=4.
module tb_game_state_ctl;
   import state_pkg::*;

   logic        clk_40 = 1'b0;
   logic        rst = 1'b1;
   logic        mouse_left = 1'b0;
   logic [11:0] xpos_mouse = 12'd0;
   logic [11:0] ypos_mouse = 12'd0;
   logic [11:0] xpos_player = 12'd0;
   logic [11:0] ypos_player = 12'd0;
   logic        button_pressed = 1'b0;
   logic        vblnk = 1'b0;
   g_state      game_state;
   logic        level_start;
   logic        frame_tick;

   int n_checks = 0;
   int n_fail = 0;

   // Per-frame observations
   g_state gs_tick, gs_n2;
   logic   tick_n, tick_n1, ls_n2, ls_n3;
   int     ticks;

   game_state_ctl #(
      .FINISH_FRAMES (4)
   ) dut (
      .clk_40         (clk_40),
      .rst            (rst),
      .mouse_left     (mouse_left),
      .xpos_mouse     (xpos_mouse),
      .ypos_mouse     (ypos_mouse),
      .xpos_player    (xpos_player),
      .ypos_player    (ypos_player),
      .button_pressed (button_pressed),
      .vblnk          (vblnk),
      .game_state     (game_state),
      .level_start    (level_start),
      .frame_tick     (frame_tick)
   );

   always #5 clk_40 = ~clk_40;

   task automatic step();
      @(posedge clk_40);
      #1;
   endtask

   // One frame: vblnk rises (sampled at edge N), then falls after a few cycles.
   task automatic do_frame();
      ticks = 0;
      vblnk = 1'b1;
      step(); tick_n = frame_tick; ticks += int'(frame_tick);
      step(); tick_n1 = frame_tick; gs_tick = game_state; ticks += int'(frame_tick);
      step(); gs_n2 = game_state; ls_n2 = level_start; ticks += int'(frame_tick);
      step(); ls_n3 = level_start; ticks += int'(frame_tick);
      vblnk = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(); ticks += int'(frame_tick);
      end
   endtask

   task automatic click();
      mouse_left = 1'b1;
      repeat (3) step();
      mouse_left = 1'b0;
      repeat (5) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      n_checks++;
      if (game_state !== START) begin
         n_fail++; $display("FAIL reset_state: got %0d want %0d", game_state, START);
      end
      n_checks++;
      if (level_start !== 1'b0) begin
         n_fail++; $display("FAIL reset_level_start: got %b want 0", level_start);
      end
      n_checks++;
      if (frame_tick !== 1'b0) begin
         n_fail++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick);
      end
      n_checks++;
      if (dut.fin_cnt_q !== 3'd0 || dut.start_pend_q !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_internal: fin_cnt %0d pend %b want 0 0", dut.fin_cnt_q,
                  dut.start_pend_q);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_idle_frames();
      for (int f = 0; f < 3; f++) begin
         do_frame();
         n_checks++;
         if (tick_n !== 1'b0 || tick_n1 !== 1'b1 || ticks != 1) begin
            n_fail++;
            $display("FAIL idle_tick f%0d: n=%b n1=%b count=%0d want 0 1 1", f, tick_n,
                     tick_n1, ticks);
         end
         n_checks++;
         if (gs_n2 !== START || ls_n2 !== 1'b0 || ls_n3 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_state f%0d: gs=%0d ls=%b%b want 0 00", f, gs_n2, ls_n2, ls_n3);
         end
      end
   endtask

   task automatic test_miss_and_hold();
      // x = X+W is just outside the button.
      xpos_mouse = 12'd450; ypos_mouse = 12'd300;
      click();
      for (int f = 0; f < 2; f++) begin
         do_frame();
         n_checks++;
         if (gs_n2 !== START) begin
            n_fail++; $display("FAIL miss_edge f%0d: got %0d want %0d", f, gs_n2, START);
         end
      end
      // Press outside, then slide onto the button while held: no new edge.
      mouse_left = 1'b1;
      repeat (6) step();
      xpos_mouse = 12'd400;
      repeat (3) step();
      do_frame();
      n_checks++;
      if (gs_n2 !== START) begin
         n_fail++; $display("FAIL held_no_retrigger: got %0d want %0d", gs_n2, START);
      end
      mouse_left = 1'b0;
      repeat (4) step();
   endtask

   task automatic test_start_click();
      xpos_mouse = 12'd400; ypos_mouse = 12'd300;
      click();
      n_checks++;
      if (game_state !== START) begin
         n_fail++; $display("FAIL click_midframe: got %0d want %0d", game_state, START);
      end
      do_frame();
      n_checks++;
      if (gs_tick !== START || tick_n1 !== 1'b1) begin
         n_fail++;
         $display("FAIL click_tick_cycle: gs=%0d tick=%b want 0 1", gs_tick, tick_n1);
      end
      n_checks++;
      if (gs_n2 !== LEVEL_1) begin
         n_fail++; $display("FAIL click_to_level: got %0d want %0d", gs_n2, LEVEL_1);
      end
      n_checks++;
      if (ls_n2 !== 1'b1 || ls_n3 !== 1'b0) begin
         n_fail++; $display("FAIL level_start_pulse: got %b%b want 10", ls_n2, ls_n3);
      end
   endtask

   task automatic test_exit();
      // x = EXIT_X+EXIT_W is outside the exit.
      xpos_player = 12'd800; ypos_player = 12'd550; button_pressed = 1'b1;
      do_frame();
      n_checks++;
      if (gs_n2 !== LEVEL_1) begin
         n_fail++; $display("FAIL exit_x_boundary: got %0d want %0d", gs_n2, LEVEL_1);
      end
      // Exit valid but button released before the tick.
      xpos_player = 12'd760;
      repeat (3) step();
      button_pressed = 1'b0;
      step();
      do_frame();
      n_checks++;
      if (gs_n2 !== LEVEL_1) begin
         n_fail++; $display("FAIL exit_button_dropped: got %0d want %0d", gs_n2, LEVEL_1);
      end
      button_pressed = 1'b1;
      do_frame();
      n_checks++;
      if (gs_n2 !== FINISH || ls_n2 !== 1'b0) begin
         n_fail++;
         $display("FAIL exit_to_finish: gs=%0d ls=%b want %0d 0", gs_n2, ls_n2, FINISH);
      end
      n_checks++;
      if (dut.fin_cnt_q !== 3'd0) begin
         n_fail++; $display("FAIL finish_cnt_clear: got %0d want 0", dut.fin_cnt_q);
      end
   endtask

   task automatic test_finish();
      xpos_mouse = 12'd400; ypos_mouse = 12'd300;
      for (int f = 1; f <= 3; f++) begin
         click();
         do_frame();
         n_checks++;
         if (gs_n2 !== FINISH || dut.fin_cnt_q !== 3'(f)) begin
            n_fail++;
            $display("FAIL finish_hold f%0d: gs=%0d cnt=%0d want %0d %0d", f, gs_n2,
                     dut.fin_cnt_q, FINISH, f);
         end
      end
      click();
      do_frame();
      n_checks++;
      if (gs_tick !== FINISH || gs_n2 !== START || ls_n2 !== 1'b0) begin
         n_fail++;
         $display("FAIL finish_return: before=%0d after=%0d ls=%b want %0d %0d 0", gs_tick,
                  gs_n2, ls_n2, FINISH, START);
      end
      // Clicks made during FINISH must not leave a pending start.
      do_frame();
      n_checks++;
      if (gs_n2 !== START) begin
         n_fail++; $display("FAIL finish_click_ignored: got %0d want %0d", gs_n2, START);
      end
   endtask

   task automatic test_reset_mid();
      click();
      do_frame();
      n_checks++;
      if (gs_n2 !== LEVEL_1) begin
         n_fail++; $display("FAIL rst_setup_level: got %0d want %0d", gs_n2, LEVEL_1);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (game_state !== START || level_start !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_in_level: gs=%0d ls=%b want %0d 0", game_state, level_start, START);
      end
      click();
      do_frame();
      do_frame();
      do_frame();
      n_checks++;
      if (game_state !== FINISH || dut.fin_cnt_q !== 3'd1) begin
         n_fail++;
         $display("FAIL rst_setup_finish: gs=%0d cnt=%0d want %0d 1", game_state,
                  dut.fin_cnt_q, FINISH);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (game_state !== START || dut.fin_cnt_q !== 3'd0) begin
         n_fail++;
         $display("FAIL rst_in_finish: gs=%0d cnt=%0d want %0d 0", game_state, dut.fin_cnt_q,
                  START);
      end
      repeat (3) step();
   endtask

   task automatic test_coincident();
      xpos_mouse = 12'd400; ypos_mouse = 12'd300;
      // Press two cycles before vblnk so the click edge and frame_tick coincide.
      mouse_left = 1'b1;
      step(); step();
      do_frame();
      mouse_left = 1'b0;
      n_checks++;
      if (gs_tick !== START || gs_n2 !== LEVEL_1 || ls_n2 !== 1'b1) begin
         n_fail++;
         $display("FAIL coincident_click: before=%0d after=%0d ls=%b want %0d %0d 1", gs_tick,
                  gs_n2, ls_n2, START, LEVEL_1);
      end
      n_checks++;
      if (dut.start_pend_q !== 1'b0) begin
         n_fail++; $display("FAIL coincident_pend: got %b want 0", dut.start_pend_q);
      end
   endtask

   initial begin
      test_reset();
      test_idle_frames();
      test_miss_and_hold();
      test_start_click();
      test_exit();
      test_finish();
      test_reset_mid();
      test_coincident();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
